two_port_ram_arbiter: RTL

//  Shares one 512x4096 simple dual-port RAM (1 write port, 1 registered read port) between two

---
 rtl/two_port_ram_arbiter.sv | 79 +++++++
 1 files changed

// File: rtl/two_port_ram_arbiter.sv
// two_port_ram_arbiter: round-robin write/read arbitration, hazard guard and zero-fill for one shared SDP RAM
module two_port_ram_arbiter #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          wr_req,
    input  logic [2*ADDR_W-1:0] wr_addr,
    input  logic [2*DATA_W-1:0] wr_data,
    output logic [1:0]          wr_gnt,
    input  logic [1:0]          rd_req,
    input  logic [2*ADDR_W-1:0] rd_addr,
    output logic [1:0]          rd_gnt,
    output logic                rd_rvalid,
    output logic                rd_rid,
    output logic [DATA_W-1:0]   rd_rdata,
    input  logic                rd_rready,
    output logic                ram_w_en,
    output logic [ADDR_W-1:0]   ram_w_addr,
    output logic [DATA_W-1:0]   ram_w_data,
    output logic                ram_r_en,
    output logic [ADDR_W-1:0]   ram_r_addr,
    input  logic [DATA_W-1:0]   ram_r_data,
    input  logic                clr_start,
    output logic                clr_busy,
    output logic                clr_done
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] rd_addr_sel;
    logic              wr_last, rd_last, wr_sel, rd_sel, idle, hazard, rd_ok;

    // grants are suppressed while reset is held so the RAM ports stay quiet
    assign idle        = rst_n & (state == IDLE);
    assign clr_busy    = (state == CLEAR);
    assign wr_sel      = &wr_req ? ~wr_last : wr_req[1];
    assign rd_sel      = &rd_req ? ~rd_last : rd_req[1];
    assign wr_gnt      = (idle & |wr_req) ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;
    assign ram_w_en    = clr_busy | (|wr_gnt);
    assign ram_w_addr  = clr_busy ? clr_cnt : (wr_sel ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0]);
    assign ram_w_data  = clr_busy ? '0 : (wr_sel ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0]);
    assign rd_addr_sel = rd_sel ? rd_addr[2*ADDR_W-1:ADDR_W] : rd_addr[ADDR_W-1:0];
    // a read of the address being written this cycle waits one cycle and sees the new data
    assign hazard      = ram_w_en & (ram_w_addr == rd_addr_sel);
    assign rd_ok       = idle & |rd_req & (~rd_rvalid | rd_rready) & ~hazard;
    assign rd_gnt      = rd_ok ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;
    assign ram_r_en    = rd_ok;
    assign ram_r_addr  = rd_addr_sel;
    assign rd_rdata    = ram_r_data;

    always_comb begin
        state_nx = (state == IDLE && clr_start) ? CLEAR :
                   (state == CLEAR && &clr_cnt) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            clr_done  <= 1'b0;
            rd_rvalid <= 1'b0;
            rd_rid    <= 1'b0;
            wr_last   <= 1'b1;
            rd_last   <= 1'b1;
        end else begin
            state     <= state_nx;
            clr_done  <= clr_busy & &clr_cnt;
            rd_rvalid <= rd_ok | (rd_rvalid & ~rd_rready);
            if (clr_busy) clr_cnt <= clr_cnt + 1'b1;
            if (|wr_gnt) wr_last <= wr_sel;
            if (rd_ok) begin
                rd_last <= rd_sel;
                rd_rid  <= rd_sel;
            end
        end
    end
endmodule
